// File: rtl/d8_text_mem_wr_ctl.sv
// Text-memory write controller: queues CPU character writes and drains them to the
// single text RAM port whenever video scanout releases it.
module d8_text_mem_wr_ctl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    output logic              cpu_stall,
    input  logic              vid_busy,
    output logic              tm_we,
    output logic [ADDR_W-1:0] tm_addr,
    output logic [7:0]        tm_data,
    output logic              pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + 8;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              tm_we_q, tm_we_d;
    logic [ADDR_W-1:0] tm_addr_q, tm_addr_d;
    logic [7:0]        tm_data_q, tm_data_d;

    logic full;
    logic not_empty;
    logic push;
    logic pop;

    assign full      = (count_q == CNT_FULL);
    assign not_empty = (count_q != '0);

    // Stall depends only on registered count, so a pop cannot free a slot for a
    // push within the same cycle.
    assign push = cpu_we & ~full;
    assign pop  = not_empty & ~vid_busy;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        tm_we_d   = 1'b0;
        tm_addr_d = tm_addr_q;
        tm_data_d = tm_data_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d               = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            tm_we_d                = 1'b1;
            {tm_addr_d, tm_data_d} = mem_q[rd_ptr_q];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            tm_we_q   <= 1'b0;
            tm_addr_q <= '0;
            tm_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            tm_we_q   <= tm_we_d;
            tm_addr_q <= tm_addr_d;
            tm_data_q <= tm_data_d;
        end
    end

    // Storage needs no reset: an entry is only read after being pushed.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cpu_addr, cpu_data};
        end
    end

    assign cpu_stall = full;
    assign pending   = not_empty;
    assign tm_we     = tm_we_q;
    assign tm_addr   = tm_addr_q;
    assign tm_data   = tm_data_q;

endmodule

// File: tb/tb_d8_text_mem_wr_ctl.sv
// Bench for d8_text_mem_wr_ctl: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_d8_text_mem_wr_ctl;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_data;
    logic              cpu_stall;
    logic              vid_busy;
    logic              tm_we;
    logic [ADDR_W-1:0] tm_addr;
    logic [7:0]        tm_data;
    logic              pending;

    d8_text_mem_wr_ctl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_stall (cpu_stall),
        .vid_busy  (vid_busy),
        .tm_we     (tm_we),
        .tm_addr   (tm_addr),
        .tm_data   (tm_data),
        .pending   (pending)
    );

    always #5 sys_clk = ~sys_clk;

    typedef logic [ADDR_W+7:0] ent_t;

    // Reference model: a plain FIFO of pending writes plus the registered RAM port.
    ent_t              mq[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_data;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mq.delete();
            m_we   <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
        end else begin
            logic was_full;
            ent_t e;
            was_full = (mq.size() == DEPTH);
            if (mq.size() != 0 && !vid_busy) begin
                e = mq.pop_front();
                m_we   <= 1'b1;
                m_addr <= e[ADDR_W+7:8];
                m_data <= e[7:0];
            end else begin
                m_we <= 1'b0;
            end
            if (cpu_we && !was_full) mq.push_back({cpu_addr, cpu_data});
        end
    end

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t dlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: wait for the falling edge, compare everything against the model,
    // and record any RAM write the DUT performed.
    task automatic step();
        @(negedge sys_clk);
        chk("cyc_tm_we",     32'(tm_we),     32'(m_we));
        chk("cyc_tm_addr",   32'(tm_addr),   32'(m_addr));
        chk("cyc_tm_data",   32'(tm_data),   32'(m_data));
        chk("cyc_cpu_stall", 32'(cpu_stall), 32'(mq.size() == DEPTH));
        chk("cyc_pending",   32'(pending),   32'(mq.size() != 0));
        if (tm_we === 1'b1) dlog.push_back({tm_addr, tm_data});
    endtask

    task automatic chk_log(input string name, input int n, input logic [ADDR_W-1:0] a0,
                           input int a_inc, input logic [7:0] d0);
        chk({name, "_len"}, 32'(dlog.size()), 32'(n));
        for (int i = 0; i < n && i < dlog.size(); i++) begin
            chk({name, "_addr"}, 32'(dlog[i][ADDR_W+7:8]), 32'(a0 + ADDR_W'(a_inc * i)));
            chk({name, "_data"}, 32'(dlog[i][7:0]), 32'(d0 + 8'(i)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int idx;
        int cyc;
        logic s;
        logic [15:0] busy_pat;

        // Reset held with a write request present: nothing may be queued.
        sys_rst  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 11'h005;
        cpu_data = 8'h41;
        vid_busy = 1'b0;
        repeat (3) begin
            step();
            chk("rst_tm_we", 32'(tm_we), 32'd0);
            chk("rst_tm_addr", 32'(tm_addr), 32'd0);
            chk("rst_stall", 32'(cpu_stall), 32'd0);
            chk("rst_pending", 32'(pending), 32'd0);
        end
        sys_rst = 1'b0;
        step();
        chk("t1_pending", 32'(pending), 32'd1);
        chk("t1_we_early", 32'(tm_we), 32'd0);
        cpu_we = 1'b0;
        step();
        chk("t1_we", 32'(tm_we), 32'd1);
        chk("t1_addr", 32'(tm_addr), 32'h005);
        chk("t1_data", 32'(tm_data), 32'h41);

        // Fill while scanout holds the port, then hold a fifth write.
        dlog.delete();
        vid_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_we   = 1'b1;
            cpu_addr = 11'h010 + 11'(i);
            cpu_data = 8'h30 + 8'(i);
            step();
        end
        chk("t2_full_stall", 32'(cpu_stall), 32'd1);
        cpu_addr = 11'h014;
        cpu_data = 8'h34;
        step();
        step();
        chk("t2_held_stall", 32'(cpu_stall), 32'd1);
        chk("t2_held_we", 32'(tm_we), 32'd0);
        vid_busy = 1'b0;
        step();
        chk("t2_pop1_we", 32'(tm_we), 32'd1);
        chk("t2_pop1_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("t2_pop2_we", 32'(tm_we), 32'd1);
        cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_drain_we", 32'(tm_we), 32'd1);
        end
        chk("t2_pending", 32'(pending), 32'd0);
        step();
        chk("t2_idle_we", 32'(tm_we), 32'd0);
        chk_log("t2_log", 5, 11'h010, 1, 8'h30);

        // Scanout alternating with a short burst.
        dlog.delete();
        for (int i = 0; i < 10; i++) begin
            vid_busy = ~i[0];
            cpu_we   = (i < 3);
            cpu_addr = 11'h200 + 11'(i);
            cpu_data = 8'h50 + 8'(i);
            step();
        end
        cpu_we   = 1'b0;
        vid_busy = 1'b0;
        step();
        chk_log("t3_log", 3, 11'h200, 1, 8'h50);

        // Back-to-back writes to the same cell at full drain rate.
        dlog.delete();
        for (int i = 0; i < 10; i++) begin
            cpu_we   = 1'b1;
            cpu_addr = 11'h7FF;
            cpu_data = 8'(i);
            step();
            chk("t4_no_stall", 32'(cpu_stall), 32'd0);
        end
        cpu_we = 1'b0;
        repeat (3) step();
        chk_log("t4_log", 10, 11'h7FF, 0, 8'h00);

        // Reset mid-cycle with three writes queued.
        dlog.delete();
        vid_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_we   = 1'b1;
            cpu_addr = 11'h300 + 11'(i);
            cpu_data = 8'h60 + 8'(i);
            step();
        end
        cpu_we = 1'b0;
        chk("t5_pre_pending", 32'(pending), 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t5_rst_we", 32'(tm_we), 32'd0);
        chk("t5_rst_pending", 32'(pending), 32'd0);
        step();
        sys_rst  = 1'b0;
        vid_busy = 1'b0;
        repeat (6) step();
        chk("t5_post_pending", 32'(pending), 32'd0);
        chk("t5_log_len", 32'(dlog.size()), 32'd0);

        // Pointer wrap over 2*DEPTH+3 writes with irregular scanout pressure.
        dlog.delete();
        busy_pat = 16'b0011_1110_0100_1111;
        idx = 0;
        cyc = 0;
        while ((idx < 2 * DEPTH + 3 || pending) && cyc < 300) begin
            s        = cpu_stall;
            vid_busy = busy_pat[cyc % 16];
            cpu_we   = (idx < 2 * DEPTH + 3);
            cpu_addr = 11'h100 + 11'(idx);
            cpu_data = 8'h80 + 8'(idx);
            step();
            if (cpu_we && !s) idx++;
            cyc++;
        end
        chk("t6_budget", 32'(cyc < 300), 32'd1);
        cpu_we   = 1'b0;
        vid_busy = 1'b0;
        step();
        chk_log("t6_log", 2 * DEPTH + 3, 11'h100, 1, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
